// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand selection, EX/MEM and MEM/WB forwarding,
// and load-use hazard detection for a 5-stage RV32I pipeline.
module id_ex_stage #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               flush,
   input  logic               id_valid,
   input  logic [XLEN-1:0]    id_pc,
   input  logic [XLEN-1:0]    id_rs1_data,
   input  logic [XLEN-1:0]    id_rs2_data,
   input  logic [XLEN-1:0]    id_imm,
   input  logic [RADDR_W-1:0] id_rs1,
   input  logic [RADDR_W-1:0] id_rs2,
   input  logic [RADDR_W-1:0] id_rd,
   input  logic [3:0]         id_alu_op,
   input  logic               id_src_a_pc,
   input  logic               id_src_b_imm,
   input  logic               id_reg_we,
   input  logic               id_mem_re,
   input  logic               id_mem_we,
   input  logic [RADDR_W-1:0] exmem_rd,
   input  logic               exmem_reg_we,
   input  logic [XLEN-1:0]    exmem_result,
   input  logic [RADDR_W-1:0] memwb_rd,
   input  logic               memwb_reg_we,
   input  logic [XLEN-1:0]    memwb_wdata,
   output logic               ex_valid,
   output logic [XLEN-1:0]    ex_pc,
   output logic [XLEN-1:0]    ex_alu_a,
   output logic [XLEN-1:0]    ex_alu_b,
   output logic [3:0]         ex_alu_op,
   output logic [XLEN-1:0]    ex_store_data,
   output logic [RADDR_W-1:0] ex_rd,
   output logic               ex_reg_we,
   output logic               ex_mem_re,
   output logic               ex_mem_we,
   output logic               load_use_hazard
);

   logic               valid_q;
   logic [XLEN-1:0]    pc_q;
   logic [XLEN-1:0]    rs1_data_q;
   logic [XLEN-1:0]    rs2_data_q;
   logic [XLEN-1:0]    imm_q;
   logic [RADDR_W-1:0] rs1_q;
   logic [RADDR_W-1:0] rs2_q;
   logic [RADDR_W-1:0] rd_q;
   logic [3:0]         alu_op_q;
   logic               src_a_pc_q;
   logic               src_b_imm_q;
   logic               reg_we_q;
   logic               mem_re_q;
   logic               mem_we_q;

   logic [XLEN-1:0]    fwd_rs1;
   logic [XLEN-1:0]    fwd_rs2;

   // Flush shares the reset clear so a bubble is indistinguishable from a reset slot.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid_q     <= 1'b0;
         pc_q        <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         alu_op_q    <= '0;
         src_a_pc_q  <= 1'b0;
         src_b_imm_q <= 1'b0;
         reg_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
      end else if (!stall) begin
         valid_q     <= id_valid;
         pc_q        <= id_pc;
         rs1_data_q  <= id_rs1_data;
         rs2_data_q  <= id_rs2_data;
         imm_q       <= id_imm;
         rs1_q       <= id_rs1;
         rs2_q       <= id_rs2;
         rd_q        <= id_rd;
         alu_op_q    <= id_alu_op;
         src_a_pc_q  <= id_src_a_pc;
         src_b_imm_q <= id_src_b_imm;
         reg_we_q    <= id_valid & id_reg_we;
         mem_re_q    <= id_valid & id_mem_re;
         mem_we_q    <= id_valid & id_mem_we;
      end
   end

   // EX/MEM is younger than MEM/WB, so it wins when both target the same register.
   always_comb begin
      fwd_rs1 = rs1_data_q;
      if (valid_q && exmem_reg_we && (exmem_rd != '0) && (exmem_rd == rs1_q))
         fwd_rs1 = exmem_result;
      else if (valid_q && memwb_reg_we && (memwb_rd != '0) && (memwb_rd == rs1_q))
         fwd_rs1 = memwb_wdata;
   end

   always_comb begin
      fwd_rs2 = rs2_data_q;
      if (valid_q && exmem_reg_we && (exmem_rd != '0) && (exmem_rd == rs2_q))
         fwd_rs2 = exmem_result;
      else if (valid_q && memwb_reg_we && (memwb_rd != '0) && (memwb_rd == rs2_q))
         fwd_rs2 = memwb_wdata;
   end

   assign ex_valid      = valid_q;
   assign ex_pc         = pc_q;
   assign ex_alu_a      = src_a_pc_q  ? pc_q  : fwd_rs1;
   assign ex_alu_b      = src_b_imm_q ? imm_q : fwd_rs2;
   assign ex_alu_op     = alu_op_q;
   assign ex_store_data = fwd_rs2;
   assign ex_rd         = rd_q;
   assign ex_reg_we     = reg_we_q;
   assign ex_mem_re     = mem_re_q;
   assign ex_mem_we     = mem_we_q;

   assign load_use_hazard = valid_q & mem_re_q & (rd_q != '0) & id_valid &
                            ((rd_q == id_rs1) | (rd_q == id_rs2));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected output snapshots are queued when
// stimulus is driven and popped for comparison once the stage presents them.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic        id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [3:0]  id_alu_op;
   logic        id_src_a_pc, id_src_b_imm, id_reg_we, id_mem_re, id_mem_we;
   logic [4:0]  exmem_rd, memwb_rd;
   logic        exmem_reg_we, memwb_reg_we;
   logic [31:0] exmem_result, memwb_wdata;
   logic        ex_valid;
   logic [31:0] ex_pc, ex_alu_a, ex_alu_b, ex_store_data;
   logic [3:0]  ex_alu_op;
   logic [4:0]  ex_rd;
   logic        ex_reg_we, ex_mem_re, ex_mem_we, load_use_hazard;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic        we;
      logic        re;
      logic        wr;
      logic        luh;
   } out_t;

   out_t sb[$];
   int   checks = 0;
   int   errors = 0;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
      .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
      .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm),
      .id_reg_we(id_reg_we), .id_mem_re(id_mem_re), .id_mem_we(id_mem_we),
      .exmem_rd(exmem_rd), .exmem_reg_we(exmem_reg_we), .exmem_result(exmem_result),
      .memwb_rd(memwb_rd), .memwb_reg_we(memwb_reg_we), .memwb_wdata(memwb_wdata),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
      .ex_alu_op(ex_alu_op), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
      .load_use_hazard(load_use_hazard)
   );

   always #5 clk = ~clk;

   // Reference view of the stage after loading the current id_* inputs, with no forwarding.
   function automatic out_t model();
      out_t e;
      e.valid = id_valid;
      e.pc    = id_pc;
      e.a     = id_src_a_pc ? id_pc : id_rs1_data;
      e.b     = id_src_b_imm ? id_imm : id_rs2_data;
      e.op    = id_alu_op;
      e.sd    = id_rs2_data;
      e.rd    = id_rd;
      e.we    = id_valid & id_reg_we;
      e.re    = id_valid & id_mem_re;
      e.wr    = id_valid & id_mem_we;
      e.luh   = id_valid & id_mem_re & (id_rd != 5'd0) &
                ((id_rd == id_rs1) | (id_rd == id_rs2));
      return e;
   endfunction

   function automatic out_t sample();
      out_t s;
      s = {ex_valid, ex_pc, ex_alu_a, ex_alu_b, ex_alu_op, ex_store_data,
           ex_rd, ex_reg_we, ex_mem_re, ex_mem_we, load_use_hazard};
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall = 0; flush = 0;
      id_valid = 0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
      id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alu_op = '0;
      id_src_a_pc = 0; id_src_b_imm = 0; id_reg_we = 0; id_mem_re = 0; id_mem_we = 0;
      exmem_rd = '0; exmem_reg_we = 0; exmem_result = '0;
      memwb_rd = '0; memwb_reg_we = 0; memwb_wdata = '0;
   endtask

   task automatic randomize_id();
      id_valid = 1'($urandom); id_pc = $urandom; id_rs1_data = $urandom;
      id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom);
      id_alu_op = 4'($urandom); id_src_a_pc = 1'($urandom); id_src_b_imm = 1'($urandom);
      id_reg_we = 1'($urandom); id_mem_re = 1'($urandom); id_mem_we = 1'($urandom);
   endtask

   task automatic test_reset();
      out_t e, a;
      randomize_id();
      exmem_rd = 5'($urandom); exmem_reg_we = 1'($urandom); exmem_result = $urandom;
      memwb_rd = 5'($urandom); memwb_reg_we = 1'($urandom); memwb_wdata = $urandom;
      stall = 1'($urandom); flush = 0;
      rst = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         sb.push_back('0);
         e = sb.pop_front(); a = sample(); checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL reset_cycle%0d: got %h expected %h", i, a, e);
         end
      end
      idle_inputs();
      tick();
      rst = 0;
   endtask

   task automatic test_pass_through();
      out_t e, a;
      idle_inputs();
      id_valid = 1; id_pc = 32'h100; id_rs1_data = 32'd5; id_rs2_data = 32'd7;
      id_imm = 32'hFFFF_FFF0; id_src_b_imm = 1; id_alu_op = 4'h2;
      id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd4; id_reg_we = 1;
      sb.push_back(model());
      tick();
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e || ex_alu_a !== 32'd5 || ex_alu_b !== 32'hFFFF_FFF0 || ex_alu_op !== 4'h2) begin
         errors++;
         $display("FAIL pass_imm: got %h expected %h", a, e);
      end
      id_src_a_pc = 1; id_src_b_imm = 0; id_alu_op = 4'hC; id_mem_we = 1;
      sb.push_back(model());
      tick();
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e || ex_alu_a !== 32'h100 || ex_alu_b !== 32'd7) begin
         errors++;
         $display("FAIL pass_pc_rs2: got %h expected %h", a, e);
      end
      id_valid = 0; id_reg_we = 1; id_mem_re = 1; id_mem_we = 1; id_rd = 5'd9;
      sb.push_back(model());
      tick();
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e || ex_reg_we !== 1'b0 || ex_mem_re !== 1'b0 || ex_mem_we !== 1'b0) begin
         errors++;
         $display("FAIL invalid_enables: got %h expected %h", a, e);
      end
   endtask

   task automatic test_forward();
      out_t base, e, a;
      idle_inputs();
      id_valid = 1; id_pc = 32'h300; id_rs1 = 5'd3; id_rs1_data = 32'h11;
      id_rs2 = 5'd8; id_rs2_data = 32'h22; id_rd = 5'd9; id_reg_we = 1; id_alu_op = 4'h6;
      base = model();
      tick();
      exmem_rd = 5'd3; exmem_reg_we = 1; exmem_result = 32'hAA;
      memwb_rd = 5'd3; memwb_reg_we = 1; memwb_wdata = 32'hBB;
      e = base; e.a = 32'hAA; sb.push_back(e);
      #1;
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL fwd_exmem_priority: got %h expected %h", a, e);
      end
      exmem_reg_we = 0;
      e = base; e.a = 32'hBB; sb.push_back(e);
      #1;
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL fwd_memwb: got %h expected %h", a, e);
      end
      memwb_reg_we = 0;
      sb.push_back(base);
      #1;
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL fwd_none: got %h expected %h", a, e);
      end
      // rs2 forwarded into store data while operand B still takes the immediate
      idle_inputs();
      id_valid = 1; id_rs2 = 5'd4; id_rs2_data = 32'h44; id_imm = 32'h1234;
      id_src_b_imm = 1; id_mem_we = 1;
      base = model();
      tick();
      memwb_rd = 5'd4; memwb_reg_we = 1; memwb_wdata = 32'hCC;
      e = base; e.sd = 32'hCC; sb.push_back(e);
      #1;
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e || ex_alu_b !== 32'h1234) begin
         errors++;
         $display("FAIL fwd_store_data: got %h expected %h", a, e);
      end
      idle_inputs();
      id_valid = 0; id_rs1 = 5'd3; id_rs1_data = 32'h11;
      base = model();
      tick();
      exmem_rd = 5'd3; exmem_reg_we = 1; exmem_result = 32'hAA;
      sb.push_back(base);
      #1;
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e || ex_alu_a !== 32'h11) begin
         errors++;
         $display("FAIL fwd_gated_invalid: got %h expected %h", a, e);
      end
   endtask

   task automatic test_x0_guard();
      out_t base, e, a;
      idle_inputs();
      id_valid = 1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_data = '0; id_rs2_data = '0;
      id_alu_op = 4'h2; id_rd = 5'd6; id_reg_we = 1;
      base = model();
      tick();
      exmem_rd = 5'd0; exmem_reg_we = 1; exmem_result = 32'h55;
      memwb_rd = 5'd0; memwb_reg_we = 1; memwb_wdata = 32'h66;
      sb.push_back(base);
      #1;
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e || ex_alu_b !== 32'd0) begin
         errors++;
         $display("FAIL x0_guard: got %h expected %h", a, e);
      end
   endtask

   task automatic test_stall_flush();
      out_t hold, e, a;
      idle_inputs();
      id_valid = 1; id_pc = 32'h200; id_rs1_data = 32'h1111; id_rs2_data = 32'h2222;
      id_imm = 32'h33; id_rs1 = 5'd10; id_rs2 = 5'd11; id_rd = 5'd12;
      id_alu_op = 4'hF; id_reg_we = 1;
      hold = model();
      tick();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         randomize_id();
         id_mem_re = 0;
         tick();
         sb.push_back(hold);
         e = sb.pop_front(); a = sample(); checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL stall_hold%0d: got %h expected %h", i, a, e);
         end
      end
      flush = 1;
      tick();
      sb.push_back('0);
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL stall_flush_bubble: got %h expected %h", a, e);
      end
      stall = 0; flush = 0; id_valid = 1; id_mem_re = 0;
      tick();
      flush = 1;
      tick();
      sb.push_back('0);
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL flush_bubble: got %h expected %h", a, e);
      end
      flush = 0;
   endtask

   task automatic test_load_use();
      out_t base, e, a;
      idle_inputs();
      id_valid = 1; id_mem_re = 1; id_reg_we = 1; id_rd = 5'd5;
      id_rs1 = 5'd1; id_rs2 = 5'd2; id_imm = 32'h8; id_src_b_imm = 1;
      base = model();
      tick();
      id_rs1 = 5'd5;
      e = base; e.luh = 1; sb.push_back(e);
      #1;
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL luh_rs1_match: got %h expected %h", a, e);
      end
      id_rs1 = 5'd6; id_rs2 = 5'd7;
      e = base; e.luh = 0; sb.push_back(e);
      #1;
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL luh_no_match: got %h expected %h", a, e);
      end
      id_rs2 = 5'd5;
      e = base; e.luh = 1; sb.push_back(e);
      #1;
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL luh_rs2_match: got %h expected %h", a, e);
      end
      id_valid = 0;
      e = base; e.luh = 0; sb.push_back(e);
      #1;
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL luh_id_invalid: got %h expected %h", a, e);
      end
      id_valid = 1; id_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
      sb.push_back(model());
      tick();
      e = sb.pop_front(); a = sample(); checks++;
      if (a !== e || load_use_hazard !== 1'b0) begin
         errors++;
         $display("FAIL luh_rd_x0: got %h expected %h", a, e);
      end
   endtask

   task automatic test_back_to_back();
      out_t e, a;
      idle_inputs();
      for (int i = 0; i < 24; i++) begin
         randomize_id();
         sb.push_back(model());
         tick();
         e = sb.pop_front(); a = sample(); checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL back_to_back%0d: got %h expected %h", i, a, e);
         end
      end
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      test_reset();
      test_pass_through();
      test_forward();
      test_x0_guard();
      test_stall_flush();
      test_load_use();
      test_back_to_back();
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
